// File: rtl/bootram_if.sv
`default_nettype none
// ==== bootram_if : CPU, loader and RAM-side signal bundle for bootram_ctrl (rev 1.0) ====
interface bootram_if #(
  parameter int ADDR_W = 11
);
  logic              cpu_valid;
  logic              cpu_ready;
  logic [31:0]       cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [3:0]        cpu_wstrb;
  logic [31:0]       cpu_rdata;
  logic              ldr_valid;
  logic              ldr_ready;
  logic [ADDR_W-1:0] ldr_addr;
  logic [7:0]        ldr_wdata;
  logic              ram_ce;
  logic              ram_oce;
  logic              ram_wre;
  logic              ram_reset;
  logic [ADDR_W-1:0] ram_ad;
  logic [7:0]        ram_din;
  logic [7:0]        ram_dout;

  // Controller side
  modport slave (
    input  cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb,
    output cpu_ready, cpu_rdata,
    input  ldr_valid, ldr_addr, ldr_wdata,
    output ldr_ready,
    output ram_ce, ram_oce, ram_wre, ram_reset, ram_ad, ram_din,
    input  ram_dout
  );

  // Requester and RAM side
  modport master (
    output cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb,
    input  cpu_ready, cpu_rdata,
    output ldr_valid, ldr_addr, ldr_wdata,
    input  ldr_ready,
    input  ram_ce, ram_oce, ram_wre, ram_reset, ram_ad, ram_din,
    output ram_dout
  );
endinterface
`default_nettype wire

// File: rtl/bootram_ctrl.sv
`default_nettype none
// ==== bootram_ctrl : CPU/loader arbiter and byte sequencer for the 2Kx8 boot RAM (rev 1.0) ====
module bootram_ctrl #(
  parameter int ADDR_W = 11
) (
  input  logic      clk_i,
  input  logic      resetn_i,
  bootram_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CPU_RD = 3'd1,
    CPU_WR = 3'd2,
    LDR_WR = 3'd3,
    DONE   = 3'd4
  } state_e;

  localparam logic GNT_CPU = 1'b1;
  localparam logic GNT_LDR = 1'b0;

  state_e            state_q, state_d;
  logic [1:0]        k_q, k_d;
  logic              gnt_q, gnt_d;
  logic              last_q, last_d;
  logic              rd_q, rd_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ce_q, ce_d;
  logic              wre_q, wre_d;
  logic [ADDR_W-1:0] ad_q, ad_d;
  logic [7:0]        din_q, din_d;
  logic [2:0]        nxt;
  logic [ADDR_W-3:0] wbase;

  assign wbase = bus.cpu_addr[ADDR_W-1:2];

  // Lowest set strobe index >= from; 4 when none remains.
  function automatic logic [2:0] next_set(input logic [3:0] strb, input logic [2:0] from);
    logic [2:0] r;
    r = 3'd4;
    for (int i = 3; i >= 0; i--) begin
      if ((3'(i) >= from) && strb[i]) r = 3'(i);
    end
    return r;
  endfunction

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= IDLE;
      k_q     <= 2'd0;
      gnt_q   <= GNT_LDR;
      last_q  <= GNT_LDR;
      rd_q    <= 1'b0;
      rdata_q <= 32'd0;
      ce_q    <= 1'b0;
      wre_q   <= 1'b0;
      ad_q    <= '0;
      din_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      rd_q    <= rd_d;
      rdata_q <= rdata_d;
      ce_q    <= ce_d;
      wre_q   <= wre_d;
      ad_q    <= ad_d;
      din_q   <= din_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    rd_d    = rd_q;
    rdata_d = rdata_q;
    ce_d    = 1'b0;
    wre_d   = 1'b0;
    ad_d    = ad_q;
    din_d   = din_q;
    nxt     = 3'd4;
    case (state_q)
      IDLE: begin
        if (bus.cpu_valid && (!bus.ldr_valid || (last_q == GNT_LDR))) begin
          gnt_d = GNT_CPU;
          ce_d  = 1'b1;
          if (bus.cpu_wstrb == 4'd0) begin
            rd_d    = 1'b1;
            k_d     = 2'd0;
            ad_d    = {wbase, 2'd0};
            state_d = CPU_RD;
          end else begin
            rd_d    = 1'b0;
            nxt     = next_set(bus.cpu_wstrb, 3'd0);
            k_d     = nxt[1:0];
            wre_d   = 1'b1;
            ad_d    = {wbase, nxt[1:0]};
            din_d   = bus.cpu_wdata[{nxt[1:0], 3'b000} +: 8];
            state_d = CPU_WR;
          end
        end else if (bus.ldr_valid) begin
          gnt_d   = GNT_LDR;
          rd_d    = 1'b0;
          ce_d    = 1'b1;
          wre_d   = 1'b1;
          ad_d    = bus.ldr_addr;
          din_d   = bus.ldr_wdata;
          state_d = LDR_WR;
        end
      end
      CPU_RD: begin
        // ram_dout now carries the byte addressed in the previous cycle.
        if (k_q != 2'd0) rdata_d[{k_q - 2'd1, 3'b000} +: 8] = bus.ram_dout;
        if (k_q != 2'd3) begin
          k_d  = k_q + 2'd1;
          ce_d = 1'b1;
          ad_d = {wbase, k_q + 2'd1};
        end else begin
          state_d = DONE;
        end
      end
      CPU_WR: begin
        nxt = next_set(bus.cpu_wstrb, {1'b0, k_q} + 3'd1);
        if (!nxt[2]) begin
          k_d   = nxt[1:0];
          ce_d  = 1'b1;
          wre_d = 1'b1;
          ad_d  = {wbase, nxt[1:0]};
          din_d = bus.cpu_wdata[{nxt[1:0], 3'b000} +: 8];
        end else begin
          state_d = DONE;
        end
      end
      LDR_WR: state_d = DONE;
      DONE: begin
        if ((gnt_q == GNT_CPU) && rd_q) rdata_d[31:24] = bus.ram_dout;
        last_d  = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The top byte arrives in the ready cycle itself, so it is forwarded live from the RAM.
  assign bus.cpu_rdata = ((state_q == DONE) && (gnt_q == GNT_CPU) && rd_q)
                         ? {bus.ram_dout, rdata_q[23:0]} : rdata_q;
  assign bus.cpu_ready = (state_q == DONE) && (gnt_q == GNT_CPU);
  assign bus.ldr_ready = (state_q == DONE) && (gnt_q == GNT_LDR);
  assign bus.ram_ce    = ce_q;
  assign bus.ram_wre   = wre_q;
  assign bus.ram_ad    = ad_q;
  assign bus.ram_din   = din_q;
  assign bus.ram_oce   = 1'b1;
  assign bus.ram_reset = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_bootram_ctrl.sv
`default_nettype none
// Directed bench for bootram_ctrl with a behavioural 2Kx8 bypass-mode RAM.
module tb_bootram_ctrl;

  logic clk;
  logic resetn;
  int   checks;
  int   failures;

  logic [7:0]  mem [0:2047];
  logic [10:0] wr_ad  [$];
  logic [7:0]  wr_dat [$];

  bootram_if #(.ADDR_W(11)) bus ();

  bootram_ctrl #(.ADDR_W(11)) dut (
    .clk_i    (clk),
    .resetn_i (resetn),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.ram_ce) begin
      if (bus.ram_wre) begin
        mem[bus.ram_ad] <= bus.ram_din;
        bus.ram_dout    <= bus.ram_din;
        wr_ad.push_back(bus.ram_ad);
        wr_dat.push_back(bus.ram_din);
      end else begin
        bus.ram_dout <= mem[bus.ram_ad];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic ldr_write(input logic [10:0] a, input logic [7:0] d);
    int n;
    int base;
    base = wr_ad.size();
    bus.ldr_valid = 1'b1;
    bus.ldr_addr  = a;
    bus.ldr_wdata = d;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.ldr_ready !== 1'b1 && n < 10);
    chk("ldr_latency", n, 2);
    chk("ldr_wre_count", wr_ad.size() - base, 1);
    chk("ldr_wr_addr", {21'd0, wr_ad[base]}, {21'd0, a});
    chk("ldr_wr_data", {24'd0, wr_dat[base]}, {24'd0, d});
    bus.ldr_valid = 1'b0;
    tick();
  endtask

  task automatic cpu_read(input logic [31:0] a, input logic [31:0] exp);
    bus.cpu_valid = 1'b1;
    bus.cpu_addr  = a;
    bus.cpu_wstrb = 4'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rd_ce", {31'd0, bus.ram_ce}, 1);
      chk("rd_wre", {31'd0, bus.ram_wre}, 0);
      chk("rd_ad", {21'd0, bus.ram_ad}, {21'd0, a[10:0]} + 32'(i));
    end
    tick();
    chk("rd_ready", {31'd0, bus.cpu_ready}, 1);
    chk("rd_data", bus.cpu_rdata, exp);
    bus.cpu_valid = 1'b0;
    tick();
    chk("rd_hold", bus.cpu_rdata, exp);
  endtask

  int base;
  int n;
  int cpu1;
  int cpu2;
  int ldr1;
  logic [31:0] rd_snap;

  initial begin
    checks        = 0;
    failures      = 0;
    resetn        = 1'b0;
    bus.cpu_valid = 1'b0;
    bus.cpu_addr  = 32'd0;
    bus.cpu_wdata = 32'd0;
    bus.cpu_wstrb = 4'd0;
    bus.ldr_valid = 1'b0;
    bus.ldr_addr  = 11'd0;
    bus.ldr_wdata = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cpu_ready", {31'd0, bus.cpu_ready}, 0);
    chk("rst_ldr_ready", {31'd0, bus.ldr_ready}, 0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 0);
    chk("rst_ram_ce", {31'd0, bus.ram_ce}, 0);
    chk("rst_ram_wre", {31'd0, bus.ram_wre}, 0);
    chk("rst_ram_ad", {21'd0, bus.ram_ad}, 0);
    chk("rst_ram_din", {24'd0, bus.ram_din}, 0);
    chk("ram_oce", {31'd0, bus.ram_oce}, 1);
    chk("ram_reset", {31'd0, bus.ram_reset}, 0);
    resetn = 1'b1;
    tick();

    ldr_write(11'h010, 8'h11);
    ldr_write(11'h011, 8'h22);
    ldr_write(11'h012, 8'h33);
    ldr_write(11'h013, 8'h44);

    cpu_read(32'h0000_0010, 32'h4433_2211);

    // Sparse-strobe write: only bytes 1 and 3 get RAM cycles.
    base = wr_ad.size();
    bus.cpu_valid = 1'b1;
    bus.cpu_addr  = 32'h0000_0010;
    bus.cpu_wdata = 32'hAABB_CCDD;
    bus.cpu_wstrb = 4'b1010;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.cpu_ready !== 1'b1 && n < 10);
    chk("wr_latency", n, 3);
    chk("wr_count", wr_ad.size() - base, 2);
    chk("wr0_addr", {21'd0, wr_ad[base]}, 32'h011);
    chk("wr0_data", {24'd0, wr_dat[base]}, 32'hCC);
    chk("wr1_addr", {21'd0, wr_ad[base+1]}, 32'h013);
    chk("wr1_data", {24'd0, wr_dat[base+1]}, 32'hAA);
    bus.cpu_valid = 1'b0;
    tick();

    cpu_read(32'h0000_0010, 32'hAA33_CC11);

    // Reset during the second byte of a full-word write.
    base = wr_ad.size();
    bus.cpu_valid = 1'b1;
    bus.cpu_addr  = 32'h0000_0040;
    bus.cpu_wdata = 32'hDEAD_BEEF;
    bus.cpu_wstrb = 4'hF;
    tick();
    tick();
    chk("ab_ce_before", {31'd0, bus.ram_ce}, 1);
    chk("ab_ad_before", {21'd0, bus.ram_ad}, 32'h041);
    resetn = 1'b0;
    #1;
    chk("ab_ce", {31'd0, bus.ram_ce}, 0);
    chk("ab_wre", {31'd0, bus.ram_wre}, 0);
    chk("ab_ad", {21'd0, bus.ram_ad}, 0);
    chk("ab_din", {24'd0, bus.ram_din}, 0);
    chk("ab_rdata", bus.cpu_rdata, 0);
    chk("ab_ready", {31'd0, bus.cpu_ready}, 0);
    bus.cpu_valid = 1'b0;
    tick();
    chk("ab_ready_hold", {31'd0, bus.cpu_ready}, 0);
    tick();
    chk("ab_wr_count", wr_ad.size() - base, 1);
    chk("ab_wr_addr", {21'd0, wr_ad[base]}, 32'h040);
    chk("ab_wr_data", {24'd0, wr_dat[base]}, 32'hEF);
    resetn = 1'b1;

    // Tie straight after reset, both held: CPU, then loader, then CPU again.
    base = wr_ad.size();
    bus.cpu_valid = 1'b1;
    bus.cpu_addr  = 32'h0000_0010;
    bus.cpu_wstrb = 4'd0;
    bus.ldr_valid = 1'b1;
    bus.ldr_addr  = 11'h020;
    bus.ldr_wdata = 8'h5A;
    cpu1 = 0;
    cpu2 = 0;
    ldr1 = 0;
    rd_snap = 32'd0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (bus.cpu_ready === 1'b1) begin
        if (cpu1 == 0) begin
          cpu1    = c;
          rd_snap = bus.cpu_rdata;
        end else if (cpu2 == 0) begin
          cpu2 = c;
          bus.cpu_valid = 1'b0;
        end
      end
      if (bus.ldr_ready === 1'b1 && ldr1 == 0) begin
        ldr1 = c;
        bus.ldr_valid = 1'b0;
      end
      if (cpu2 != 0) break;
    end
    bus.cpu_valid = 1'b0;
    bus.ldr_valid = 1'b0;
    chk("tie_cpu_first", cpu1, 5);
    chk("tie_cpu_data", rd_snap, 32'hAA33_CC11);
    chk("tie_ldr_second", ldr1, 8);
    chk("tie_cpu_third", cpu2, 14);
    chk("tie_ldr_wr_addr", {21'd0, wr_ad[base]}, 32'h020);
    chk("tie_ldr_wr_data", {24'd0, wr_dat[base]}, 32'h5A);
    tick();

    // CPU valid held across ready: one IDLE cycle, then a fresh read.
    bus.cpu_valid = 1'b1;
    bus.cpu_addr  = 32'h0000_0012;
    bus.cpu_wstrb = 4'd0;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.cpu_ready !== 1'b1 && n < 10);
    chk("held_first_lat", n, 5);
    chk("held_first_data", bus.cpu_rdata, 32'hAA33_CC11);
    tick();
    chk("held_gap_ce", {31'd0, bus.ram_ce}, 0);
    chk("held_gap_ready", {31'd0, bus.cpu_ready}, 0);
    tick();
    chk("held_regrant_ce", {31'd0, bus.ram_ce}, 1);
    chk("held_regrant_ad", {21'd0, bus.ram_ad}, 32'h010);
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.cpu_ready !== 1'b1 && n < 10);
    chk("held_second_lat", n, 4);
    chk("held_second_data", bus.cpu_rdata, 32'hAA33_CC11);
    bus.cpu_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
